// File: rtl/psum_collector.sv
// Partial-sum collector: accumulates K signed partial sums from a PE chain,
// requantizes the group total (round-half-up arithmetic shift, optional ReLU,
// saturation to O_Y bits) and queues results in a first-word-fall-through FIFO.
module psum_collector #(
    parameter int I_PSUM = 19,
    parameter int O_ACC  = 24,
    parameter int K      = 3,
    parameter int SHIFT  = 4,
    parameter int O_Y    = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic signed [I_PSUM-1:0]  i_psum,
    output logic                      o_ready,
    input  logic                      i_relu_en,
    output logic                      o_valid,
    output logic signed [O_Y-1:0]     o_y,
    input  logic                      i_ready,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (K > 1) ? $clog2(K) : 1;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(K - 1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Rounding constant and output clamp limits, held one bit wider than the
    // accumulator so the rounding add can never wrap.
    localparam logic        [O_ACC:0] ROUND = (O_ACC + 1)'(1) << (SHIFT - 1);
    localparam logic signed [O_ACC:0] Y_MAX = (O_ACC + 1)'((1 << (O_Y - 1)) - 1);
    localparam logic signed [O_ACC:0] Y_MIN = ~Y_MAX;

    logic signed [O_ACC-1:0] acc_reg;
    logic        [BW-1:0]    beat_reg;
    logic        [PW-1:0]    wr_ptr_reg;
    logic        [PW-1:0]    rd_ptr_reg;
    logic        [CW-1:0]    count_reg;
    logic                    live_reg;

    logic signed [O_Y-1:0]   mem [DEPTH];

    logic signed [O_ACC-1:0] psum_ext;
    logic signed [O_ACC:0]   sum_wide;
    logic signed [O_ACC:0]   shifted;
    logic signed [O_ACC:0]   clipped;
    logic signed [O_Y-1:0]   y_next;

    logic accept;
    logic last_beat;
    logic push;
    logic pop;

    // Handshake decode; o_ready depends only on registered state so there is
    // no combinational path from i_ready. live_reg keeps o_ready low during
    // reset and releases it one edge after reset deassertion.
    always_comb begin
        o_ready   = live_reg && (count_reg < FULL_COUNT);
        o_valid   = (count_reg != '0);
        o_count   = count_reg;
        o_y       = o_valid ? mem[rd_ptr_reg] : '0;
        accept    = i_valid && o_ready;
        last_beat = (beat_reg == LAST_BEAT);
        push      = accept && last_beat;
        pop       = o_valid && i_ready;
    end

    // Group total, rounding shift, optional ReLU and saturation to O_Y bits.
    always_comb begin
        psum_ext = O_ACC'(i_psum);
        sum_wide = {acc_reg[O_ACC-1], acc_reg} + {psum_ext[O_ACC-1], psum_ext} + ROUND;
        shifted  = sum_wide >>> SHIFT;
        clipped  = shifted;
        if (i_relu_en && shifted[O_ACC]) begin
            clipped = '0;
        end
        if (clipped > Y_MAX) begin
            y_next = O_Y'(Y_MAX);
        end else if (clipped < Y_MIN) begin
            y_next = O_Y'(Y_MIN);
        end else begin
            y_next = O_Y'(clipped);
        end
    end

    // Ready-enable flag: cleared by reset, set on the first edge afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_reg <= 1'b0;
        end else begin
            live_reg <= 1'b1;
        end
    end

    // Accumulator and beat counter; both hold whenever no beat is accepted,
    // and restart from zero on the K-th beat so the next group has no bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_reg  <= '0;
            beat_reg <= '0;
        end else if (accept) begin
            if (last_beat) begin
                acc_reg  <= '0;
                beat_reg <= '0;
            end else begin
                acc_reg  <= acc_reg + psum_ext;
                beat_reg <= beat_reg + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle cancel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage; contents need no reset because o_y is gated by o_valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= y_next;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed self-checking bench for psum_collector with default parameters
// (K=3, SHIFT=4, O_Y=8, DEPTH=4).
module tb_psum_collector;

    localparam int I_PSUM = 19;
    localparam int O_Y    = 8;
    localparam int DEPTH  = 4;

    logic                     i_clk;
    logic                     i_rst_n;
    logic                     i_valid;
    logic signed [I_PSUM-1:0] i_psum;
    logic                     o_ready;
    logic                     i_relu_en;
    logic                     o_valid;
    logic signed [O_Y-1:0]    o_y;
    logic                     i_ready;
    logic [$clog2(DEPTH):0]   o_count;

    int pass_cnt  = 0;
    int check_cnt = 0;

    psum_collector dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_psum    (i_psum),
        .o_ready   (o_ready),
        .i_relu_en (i_relu_en),
        .o_valid   (o_valid),
        .o_y       (o_y),
        .i_ready   (i_ready),
        .o_count   (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Present one beat for one clock edge (caller guarantees o_ready is high).
    task automatic beat(input int v, input logic relu);
        i_valid   = 1'b1;
        i_psum    = I_PSUM'(v);
        i_relu_en = relu;
        @(posedge i_clk);
        #1;
        i_valid   = 1'b0;
        i_relu_en = 1'b0;
        $display("beat psum=%0d relu=%0b count=%0d", v, relu, o_count);
    endtask

    // Consume the FIFO head for one clock edge.
    task automatic pop_one();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        check_cnt++; if (o_ready !== 1'b0) $display("FAIL reset_ready got=%0b want=0", o_ready); else pass_cnt++;
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", o_valid); else pass_cnt++;
        check_cnt++; if (o_y !== 8'sd0) $display("FAIL reset_y got=%0d want=0", o_y); else pass_cnt++;
        check_cnt++; if (o_count !== 3'd0) $display("FAIL reset_count got=%0d want=0", o_count); else pass_cnt++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_cnt++; if (o_ready !== 1'b0) $display("FAIL release_ready_early got=%0b want=0", o_ready); else pass_cnt++;
        @(posedge i_clk);
        #1;
        check_cnt++; if (o_ready !== 1'b1) $display("FAIL release_ready got=%0b want=1", o_ready); else pass_cnt++;
        $display("reset done ready=%0b count=%0d", o_ready, o_count);
    endtask

    task automatic test_basic();
        i_ready = 1'b0;
        beat(100, 1'b0);
        beat(200, 1'b0);
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL basic_early_valid got=%0b want=0", o_valid); else pass_cnt++;
        beat(300, 1'b0);
        check_cnt++; if (o_valid !== 1'b1) $display("FAIL basic_valid got=%0b want=1", o_valid); else pass_cnt++;
        check_cnt++; if (o_y !== 8'sd38) $display("FAIL basic_y got=%0d want=38", o_y); else pass_cnt++;
        check_cnt++; if (o_count !== 3'd1) $display("FAIL basic_count got=%0d want=1", o_count); else pass_cnt++;
        pop_one();
        check_cnt++; if (o_count !== 3'd0) $display("FAIL basic_pop_count got=%0d want=0", o_count); else pass_cnt++;
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL basic_pop_valid got=%0b want=0", o_valid); else pass_cnt++;
    endtask

    task automatic test_negative();
        beat(-100, 1'b0); beat(-200, 1'b0); beat(-300, 1'b0);
        check_cnt++; if (o_y !== -8'sd37) $display("FAIL neg_norelu got=%0d want=-37", o_y); else pass_cnt++;
        pop_one();
        // ReLU is sampled only with the final beat of a group.
        beat(-100, 1'b0); beat(-200, 1'b0); beat(-300, 1'b1);
        check_cnt++; if (o_y !== 8'sd0) $display("FAIL neg_relu got=%0d want=0", o_y); else pass_cnt++;
        pop_one();
        beat(-100, 1'b1); beat(-200, 1'b1); beat(-300, 1'b0);
        check_cnt++; if (o_y !== -8'sd37) $display("FAIL neg_relu_early got=%0d want=-37", o_y); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_saturation();
        beat(5000, 1'b0); beat(5000, 1'b0); beat(5000, 1'b0);
        check_cnt++; if (o_y !== 8'sd127) $display("FAIL sat_pos got=%0d want=127", o_y); else pass_cnt++;
        pop_one();
        beat(-5000, 1'b0); beat(-5000, 1'b0); beat(-5000, 1'b0);
        check_cnt++; if (o_y !== -8'sd128) $display("FAIL sat_neg got=%0d want=-128", o_y); else pass_cnt++;
        pop_one();
    endtask

    task automatic test_full();
        int vals [3] = '{100, 200, 300};
        int idx  = 0;
        int pops = 0;
        i_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            beat(100, 1'b0); beat(200, 1'b0); beat(300, 1'b0);
        end
        check_cnt++; if (o_count !== 3'd4) $display("FAIL full_count got=%0d want=4", o_count); else pass_cnt++;
        check_cnt++; if (o_ready !== 1'b0) $display("FAIL full_ready got=%0b want=0", o_ready); else pass_cnt++;
        // Hold a beat on the input while full: nothing may be accepted.
        i_valid = 1'b1;
        i_psum  = I_PSUM'(100);
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        check_cnt++; if (o_count !== 3'd4) $display("FAIL full_stall_count got=%0d want=4", o_count); else pass_cnt++;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && pops < 5; cyc++) begin
            logic will_accept;
            i_valid     = (idx < 3);
            i_psum      = I_PSUM'(vals[(idx < 3) ? idx : 0]);
            will_accept = o_ready && (idx < 3);
            if (o_valid) begin
                check_cnt++; if (o_y !== 8'sd38) $display("FAIL drain_y%0d got=%0d want=38", pops, o_y); else pass_cnt++;
                $display("drain out=%0d count=%0d", o_y, o_count);
                pops++;
            end
            @(posedge i_clk);
            #1;
            if (will_accept) idx++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check_cnt++; if (pops !== 5) $display("FAIL drain_pops got=%0d want=5", pops); else pass_cnt++;
        check_cnt++; if (o_count !== 3'd0) $display("FAIL drain_count got=%0d want=0", o_count); else pass_cnt++;
    endtask

    task automatic test_order();
        i_ready = 1'b0;
        beat(10, 1'b0);    beat(20, 1'b0);    beat(30, 1'b0);
        beat(-100, 1'b0);  beat(-200, 1'b0);  beat(-300, 1'b0);
        beat(5000, 1'b0);  beat(5000, 1'b0);  beat(5000, 1'b0);
        check_cnt++; if (o_count !== 3'd3) $display("FAIL order_count got=%0d want=3", o_count); else pass_cnt++;
        check_cnt++; if (o_y !== 8'sd4) $display("FAIL order_y0 got=%0d want=4", o_y); else pass_cnt++;
        pop_one();
        check_cnt++; if (o_y !== -8'sd37) $display("FAIL order_y1 got=%0d want=-37", o_y); else pass_cnt++;
        pop_one();
        check_cnt++; if (o_y !== 8'sd127) $display("FAIL order_y2 got=%0d want=127", o_y); else pass_cnt++;
        pop_one();
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL order_empty got=%0b want=0", o_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int vals [3] = '{100, 200, 300};
        int outs = 0;
        i_ready = 1'b1;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            logic exp_valid;
            exp_valid = (cyc > 0) && (cyc % 3 == 0);
            i_valid   = (cyc < 12);
            i_psum    = I_PSUM'(vals[cyc % 3]);
            check_cnt++; if (o_valid !== exp_valid) $display("FAIL b2b_valid cyc=%0d got=%0b want=%0b", cyc, o_valid, exp_valid); else pass_cnt++;
            check_cnt++; if (o_count > 3'd1) $display("FAIL b2b_count cyc=%0d got=%0d want<=1", cyc, o_count); else pass_cnt++;
            if (o_valid) begin
                check_cnt++; if (o_y !== 8'sd38) $display("FAIL b2b_y cyc=%0d got=%0d want=38", cyc, o_y); else pass_cnt++;
                $display("b2b out=%0d cyc=%0d", o_y, cyc);
                outs++;
            end
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check_cnt++; if (outs !== 4) $display("FAIL b2b_outs got=%0d want=4", outs); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        beat(100, 1'b0); beat(200, 1'b0); beat(300, 1'b0);
        beat(100, 1'b0); beat(200, 1'b0);
        check_cnt++; if (o_valid !== 1'b1) $display("FAIL rmid_pre_valid got=%0b want=1", o_valid); else pass_cnt++;
        i_rst_n = 1'b0;
        #1;
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL rmid_valid got=%0b want=0", o_valid); else pass_cnt++;
        check_cnt++; if (o_count !== 3'd0) $display("FAIL rmid_count got=%0d want=0", o_count); else pass_cnt++;
        check_cnt++; if (o_ready !== 1'b0) $display("FAIL rmid_ready got=%0b want=0", o_ready); else pass_cnt++;
        check_cnt++; if (o_y !== 8'sd0) $display("FAIL rmid_y got=%0d want=0", o_y); else pass_cnt++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        beat(10, 1'b0); beat(20, 1'b0); beat(30, 1'b0);
        check_cnt++; if (o_y !== 8'sd4) $display("FAIL rmid_y_after got=%0d want=4", o_y); else pass_cnt++;
        check_cnt++; if (o_count !== 3'd1) $display("FAIL rmid_count_after got=%0d want=1", o_count); else pass_cnt++;
        pop_one();
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_psum    = '0;
        i_relu_en = 1'b0;
        i_ready   = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_full();
        test_order();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter I_PSUM, default 19: width of incoming signed partial sum from PE chain.
REQ-002 SHALL have parameter O_ACC, default 24: signed accumulator width.
REQ-003 SHALL have parameter K, default 3: partial sums combined per output (legal 1..32).
REQ-004 SHALL have parameter SHIFT, default 4: requantization right-shift (legal 1..O_ACC-2).
REQ-005 SHALL have parameter O_Y, default 8: signed output width.
REQ-006 SHALL have parameter DEPTH, default 4: output FIFO entries (power of two).
REQ-007 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port i_valid  input  1  i_psum valid this cycle.
REQ-010 SHALL have port i_psum  input  I_PSUM signed  partial sum from PE o_psum.
REQ-011 SHALL have port o_ready  output  1  collector accepts i_psum this cycle.
REQ-012 SHALL have port i_relu_en  input  1  clamp negative results to 0; sampled with the K-th beat.
REQ-013 SHALL have port o_valid  output  1  o_y holds valid result.
REQ-014 SHALL have port o_y  output  O_Y signed  requantized result, FIFO head.
REQ-015 SHALL have port i_ready  input  1  downstream consumes o_y when o_valid high.
REQ-016 SHALL have port o_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL accept a beat only when i_valid && o_ready; i_psum ignored otherwise.
REQ-018 SHALL sign-extend i_psum to O_ACC and add it to accumulator acc on each accepted beat.
REQ-019 SHALL track accepted beats with counter beat 0..K-1 (ACCUM state); beat wraps K-1 -> 0 on K-th accepted beat.
REQ-020 On K-th beat SHALL form sum = acc + i_psum, r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic).
REQ-021 SHALL replace r by 0 when i_relu_en=1 and r<0.
REQ-022 SHALL saturate r to [-2^(O_Y-1), 2^(O_Y-1)-1] and push it into the FIFO the same edge.
REQ-023 SHALL clear acc to 0 on the K-th beat edge so next group starts from 0 with no bubble.
REQ-024 SHALL drive o_ready = (o_count < DEPTH), registered-state only, no combinational path from i_ready.
REQ-025 SHALL be first-word-fall-through: o_valid = (o_count != 0), o_y = oldest entry.
REQ-026 SHALL pop on o_valid && i_ready; simultaneous push and pop SHALL leave o_count unchanged.
REQ-027 When full, o_ready low stalls all input beats (not just K-th); acc and beat SHALL hold.
REQ-028 Pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or go below 0.
REQ-029 Latency: result visible on o_y/o_valid the cycle after K-th beat accepted (FIFO previously empty).
REQ-030 K=1 SHALL push every accepted beat.

Reset
REQ-031 On i_rst_n=0 SHALL asynchronously clear acc, beat, FIFO pointers, o_count; o_valid=0, o_ready=0 while in reset, o_y=0.
REQ-032 o_ready SHALL go 1 the first cycle after reset release; a partial group in progress at reset SHALL be discarded.

Verification
REQ-033 K=3, SHIFT=4: beats 100,200,300, relu off -> one cycle later o_valid=1, o_y=38.
REQ-034 Beats -100,-200,-300: relu off -> o_y=-37; relu on -> o_y=0.
REQ-035 Saturation: 5000 x3 -> o_y=127; -5000 x3 -> o_y=-128.
REQ-036 i_ready=0, feed 5 groups of 100,200,300 -> o_count reaches 4, o_ready=0, 5th group stalls after 0 beats; raise i_ready -> four 38s drain in order, stalled group completes -> fifth 38.
REQ-037 Back-to-back groups with i_ready=1 continuously -> one output per 3 cycles, o_count never exceeds 1.
REQ-038 Assert i_rst_n=0 after 2 beats of a group -> outputs cleared immediately; after release beats 10,20,30 -> o_y=4.
